// File: rtl/dfs_pkg.sv
// Shared types and constants for the multi-channel DFS frequency request arbiter.
// Holds the FSM state encoding, the default operating-point table and the word lookup.
package dfs_pkg;

    localparam int FREQ_IDX_W = 8;
    localparam int N_FREQ_DEF = 6;

    typedef int freq_tbl_t [N_FREQ_DEF];

    // Highest frequency at index 0.
    localparam freq_tbl_t FREQS_DEF = '{480, 440, 400, 360, 320, 280};

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_ACK = 2'd2
    } dfs_state_e;

    // Full-width table word for an index; the caller truncates to its data width.
    function automatic logic [31:0] freq_word(input freq_tbl_t tbl,
                                              input logic [FREQ_IDX_W-1:0] idx);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < N_FREQ_DEF; i++) begin
            if (idx == FREQ_IDX_W'(i)) w = 32'(tbl[i]);
        end
        return w;
    endfunction

endpackage

// File: rtl/dfs_freq_req_arb_if.sv
// Bundle between the DVFS policy sources / DFS engine (master) and the arbiter (slave).
// Also carries the arbiter FSM state as a debug output.
interface dfs_freq_req_arb_if #(
    parameter int N_CH       = 4,
    parameter int DATA_WIDTH = 13
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // freq_valid_i is a strobe: each cycle it is high together with enable_i one index is
    // captured, no back-pressure. dfs_en_o is a one-cycle request pulse; dfs_ack_i is only
    // honoured while that request awaits acknowledgement and is ignored at any other time.
    logic [N_CH-1:0]                            enable_i;
    logic [N_CH-1:0]                            freq_valid_i;
    logic [N_CH-1:0][dfs_pkg::FREQ_IDX_W-1:0]   freq_idx_i;
    logic                                       dfs_en_o;
    logic [DATA_WIDTH-1:0]                      dfs_data_o;
    logic [CH_W-1:0]                            dfs_ch_o;
    logic                                       dfs_ack_i;
    logic [N_CH-1:0][dfs_pkg::FREQ_IDX_W-1:0]   cur_idx_o;
    logic                                       busy_o;
    logic [N_CH-1:0]                            idx_err_o;
    logic [N_CH-1:0]                            timeout_err_o;
    dfs_pkg::dfs_state_e                        state_o;

    modport master (
        output enable_i, freq_valid_i, freq_idx_i, dfs_ack_i,
        input  dfs_en_o, dfs_data_o, dfs_ch_o, cur_idx_o, busy_o,
               idx_err_o, timeout_err_o, state_o
    );

    modport slave (
        input  enable_i, freq_valid_i, freq_idx_i, dfs_ack_i,
        output dfs_en_o, dfs_data_o, dfs_ch_o, cur_idx_o, busy_o,
               idx_err_o, timeout_err_o, state_o
    );

endinterface

// File: rtl/dfs_rr_arbiter.sv
// Combinational round-robin picker: first request at or after the pointer wins.
// Produces a one-hot grant, its channel number and a valid flag.
module dfs_rr_arbiter #(
    parameter int N_CH = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N_CH-1:0] gnt_o,
    output logic [CH_W-1:0] gnt_idx_o,
    output logic            gnt_vld_o
);

    int   c;
    logic found;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        c         = 0;
        for (int i = 0; i < N_CH; i++) begin
            c = (int'(ptr_i) + i) % N_CH;
            if (!found && req_i[c]) begin
                found     = 1'b1;
                gnt_o[c]  = 1'b1;
                gnt_idx_o = CH_W'(c);
            end
        end
        gnt_vld_o = found;
    end

endmodule

// File: rtl/dfs_freq_req_arb.sv
// Multi-channel DFS request arbiter: per-channel index capture, round-robin grant,
// ack with timeout/retry. Optional single-step ramping under `DFS_RAMP_LIMIT_EN.
module dfs_freq_req_arb
    import dfs_pkg::*;
#(
    parameter int        DATA_WIDTH  = 13,
    parameter int        N_FREQ      = 6,
    parameter freq_tbl_t FREQS       = FREQS_DEF,
    parameter int        N_CH        = 4,
    parameter int        DEF_IDX     = 1,
    parameter int        ACK_TIMEOUT = 255,
    parameter int        MAX_RETRY   = 3
) (
    input logic               clk,
    input logic               rst,
    dfs_freq_req_arb_if.slave bus
);

    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [FREQ_IDX_W-1:0] DEF_IDX_L = FREQ_IDX_W'(DEF_IDX);
    localparam logic [DATA_WIDTH-1:0] DEF_WORD  = DATA_WIDTH'(FREQS[DEF_IDX]);

    dfs_state_e                     state_q;
    logic [N_CH-1:0]                pend_q, pend_d;
    logic [N_CH-1:0][FREQ_IDX_W-1:0] tgt_q, tgt_d;
    logic [N_CH-1:0][FREQ_IDX_W-1:0] cur_q, cur_d;
    logic [N_CH-1:0]                idx_err_q, idx_err_d;
    logic [N_CH-1:0]                to_err_q;
    logic [FREQ_IDX_W-1:0]          inflight_q, step_idx;
    logic [CH_W-1:0]                ch_q, rr_q, gnt_idx, ch_next;
    logic [DATA_WIDTH-1:0]          data_q;
    logic                           en_q, busy_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [RTY_W-1:0]               retry_q;
    logic [N_CH-1:0]                elig, gnt_oh;
    logic                           gnt_vld, grant, grant_keep, ack_ok, expire, give_up;

    assign elig = pend_q & bus.enable_i;

    dfs_rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req_i     (elig),
        .ptr_i     (rr_q),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx),
        .gnt_vld_o (gnt_vld)
    );

    assign grant   = (state_q == S_IDLE) && gnt_vld;
    assign ack_ok  = (state_q == S_WAIT_ACK) && bus.dfs_ack_i;
    assign expire  = (state_q == S_WAIT_ACK) && !bus.dfs_ack_i && (cnt_q <= CNT_W'(1));
    assign give_up = expire && (int'(retry_q) >= MAX_RETRY);
    assign ch_next = (int'(ch_q) == N_CH - 1) ? '0 : ch_q + 1'b1;

`ifdef DFS_RAMP_LIMIT_EN
    // Move one operating point per transaction; pend survives the grant until the target is hit.
    always_comb begin
        step_idx = cur_q[gnt_idx];
        if (tgt_q[gnt_idx] > cur_q[gnt_idx])      step_idx = cur_q[gnt_idx] + 1'b1;
        else if (tgt_q[gnt_idx] < cur_q[gnt_idx]) step_idx = cur_q[gnt_idx] - 1'b1;
    end
    assign grant_keep = (step_idx != tgt_q[gnt_idx]);
`else
    assign step_idx   = tgt_q[gnt_idx];
    assign grant_keep = 1'b0;
`endif

    // A new index is compared against what is in flight, so a request racing an ack still re-arms.
    always_comb begin
        pend_d    = pend_q;
        tgt_d     = tgt_q;
        cur_d     = cur_q;
        idx_err_d = '0;
        if (ack_ok) cur_d[ch_q] = inflight_q;
        for (int c = 0; c < N_CH; c++) begin
            if (grant && gnt_oh[c]) pend_d[c] = grant_keep;
            if (bus.enable_i[c] && bus.freq_valid_i[c]) begin
                if (int'(bus.freq_idx_i[c]) < N_FREQ) begin
                    tgt_d[c] = bus.freq_idx_i[c];
                    if (grant && gnt_oh[c])
                        pend_d[c] = (bus.freq_idx_i[c] != step_idx);
                    else if (state_q != S_IDLE && int'(ch_q) == c)
                        pend_d[c] = (bus.freq_idx_i[c] != inflight_q);
                    else
                        pend_d[c] = (bus.freq_idx_i[c] != cur_q[c]);
                end else begin
                    idx_err_d[c] = 1'b1;
                end
            end
            if (give_up && int'(ch_q) == c) pend_d[c] = 1'b1;
            if (!bus.enable_i[c])           pend_d[c] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pend_q     <= '1;
            tgt_q      <= {N_CH{DEF_IDX_L}};
            cur_q      <= {N_CH{DEF_IDX_L}};
            idx_err_q  <= '0;
            to_err_q   <= '0;
            inflight_q <= DEF_IDX_L;
            ch_q       <= '0;
            rr_q       <= '0;
            data_q     <= DEF_WORD;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            retry_q    <= '0;
        end else begin
            pend_q    <= pend_d;
            tgt_q     <= tgt_d;
            cur_q     <= cur_d;
            idx_err_q <= idx_err_d;
            en_q      <= 1'b0;
            to_err_q  <= '0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        inflight_q <= step_idx;
                        ch_q       <= gnt_idx;
                        data_q     <= DATA_WIDTH'(freq_word(FREQS, step_idx));
                        retry_q    <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    en_q    <= 1'b1;
                    cnt_q   <= CNT_W'(ACK_TIMEOUT);
                    state_q <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (bus.dfs_ack_i) begin
                        rr_q    <= ch_next;
                        retry_q <= '0;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (give_up) begin
                        to_err_q[ch_q] <= 1'b1;
                        rr_q           <= ch_next;
                        retry_q        <= '0;
                        busy_q         <= 1'b0;
                        state_q        <= S_IDLE;
                    end else if (expire) begin
                        retry_q <= retry_q + 1'b1;
                        state_q <= S_ISSUE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.dfs_en_o      = en_q;
    assign bus.dfs_data_o    = data_q;
    assign bus.dfs_ch_o      = ch_q;
    assign bus.cur_idx_o     = cur_q;
    assign bus.busy_o        = busy_q;
    assign bus.idx_err_o     = idx_err_q;
    assign bus.timeout_err_o = to_err_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_dfs_freq_req_arb.sv
// Directed bench for dfs_freq_req_arb (N_CH=4, ACK_TIMEOUT=10).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_dfs_freq_req_arb;
    import dfs_pkg::*;

    localparam int N_CH = 4;
    localparam int DW   = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dfs_freq_req_arb_if #(.N_CH(N_CH), .DATA_WIDTH(DW)) bus ();

    dfs_freq_req_arb #(
        .DATA_WIDTH  (DW),
        .N_CH        (N_CH),
        .ACK_TIMEOUT (10),
        .MAX_RETRY   (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         en_t[8];
    int         n_en, to_k, n_before, n_quiet;
    logic [3:0] to_v;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic request(input int ch, input int idx);
        bus.freq_valid_i[ch] = 1'b1;
        bus.freq_idx_i[ch]   = 8'(idx);
        tick();
        bus.freq_valid_i     = '0;
    endtask

    // Called on the sample where dfs_en_o is high: pulse must drop, then ack one cycle later.
    task automatic finish_ack(input string tag);
        tick();
        check({tag, " en single"}, 32'(bus.dfs_en_o), 32'd0);
        bus.dfs_ack_i = 1'b1;
        tick();
        bus.dfs_ack_i = 1'b0;
        check({tag, " busy after ack"}, 32'(bus.busy_o), 32'd0);
    endtask

    task automatic expect_pulse(input int ch, input int data, input string tag);
        int k;
        k = 0;
        while (bus.dfs_en_o !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check({tag, " pulse seen"}, 32'(bus.dfs_en_o), 32'd1);
        check({tag, " ch"},         32'(bus.dfs_ch_o), 32'(ch));
        check({tag, " data"},       32'(bus.dfs_data_o), 32'(data));
        check({tag, " busy"},       32'(bus.busy_o), 32'd1);
        finish_ack(tag);
    endtask

    task automatic count_en(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.dfs_en_o === 1'b1) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.enable_i     = 4'hF;
        bus.freq_valid_i = '0;
        bus.freq_idx_i   = '0;
        bus.dfs_ack_i    = 1'b0;

        // Reset values
        tick();
        tick();
        check("rst en",      32'(bus.dfs_en_o), 32'd0);
        check("rst data",    32'(bus.dfs_data_o), 32'd440);
        check("rst ch",      32'(bus.dfs_ch_o), 32'd0);
        check("rst busy",    32'(bus.busy_o), 32'd0);
        check("rst idx_err", 32'(bus.idx_err_o), 32'd0);
        check("rst to_err",  32'(bus.timeout_err_o), 32'd0);
        check("rst cur",     32'(bus.cur_idx_o), 32'h01010101);
        check("rst state",   32'(bus.state_o), 32'(S_IDLE));
        rst = 1'b0;

        // Initial programming of DEF_IDX on every channel, in channel order
        expect_pulse(0, 440, "init ch0");
        expect_pulse(1, 440, "init ch1");
        expect_pulse(2, 440, "init ch2");
        expect_pulse(3, 440, "init ch3");
        check("init cur", 32'(bus.cur_idx_o), 32'h01010101);
        count_en(4, n_quiet);
        check("init quiet", 32'(n_quiet), 32'd0);

        // ch2 -> idx 4: pulse appears on the third sample after the strobe
        request(2, 4);
        check("lat t+1 en", 32'(bus.dfs_en_o), 32'd0);
        tick();
        check("lat t+2 en",   32'(bus.dfs_en_o), 32'd0);
        check("lat t+2 busy", 32'(bus.busy_o), 32'd1);
        tick();
        check("lat t+3 en",   32'(bus.dfs_en_o), 32'd1);
        check("lat t+3 ch",   32'(bus.dfs_ch_o), 32'd2);
        check("lat t+3 data", 32'(bus.dfs_data_o), 32'd320);
        finish_ack("lat");
        check("lat cur", 32'(bus.cur_idx_o), 32'h01040101);

        // Move rr pointer to 1, then ch0 and ch3 request together: ch3 first
        request(0, 2);
        expect_pulse(0, 400, "rr prep");
        check("rr prep cur", 32'(bus.cur_idx_o), 32'h01040102);
        bus.freq_valid_i[0] = 1'b1;
        bus.freq_idx_i[0]   = 8'd3;
        bus.freq_valid_i[3] = 1'b1;
        bus.freq_idx_i[3]   = 8'd5;
        tick();
        bus.freq_valid_i    = '0;
        expect_pulse(3, 280, "rr first");
        expect_pulse(0, 360, "rr second");
        check("rr cur", 32'(bus.cur_idx_o), 32'h05040103);

        // Out-of-range on ch1 and a strobe on disabled ch0: neither issues
        bus.enable_i[0]     = 1'b0;
        bus.freq_valid_i[0] = 1'b1;
        bus.freq_idx_i[0]   = 8'd5;
        bus.freq_valid_i[1] = 1'b1;
        bus.freq_idx_i[1]   = 8'd7;
        tick();
        bus.freq_valid_i    = '0;
        check("oor idx_err pulse", 32'(bus.idx_err_o), 32'h2);
        tick();
        check("oor idx_err clear", 32'(bus.idx_err_o), 32'h0);
        count_en(8, n_quiet);
        check("oor no pulse", 32'(n_quiet), 32'd0);
        check("oor cur", 32'(bus.cur_idx_o), 32'h05040103);
        bus.enable_i[0] = 1'b1;

        // No ack: 4 pulses 11 cycles apart, timeout error, then pend re-arms
        n_en = 0;
        to_k = -1;
        to_v = '0;
        request(1, 0);
        for (int k = 1; k <= 60; k++) begin
            if (bus.dfs_en_o === 1'b1) begin
                if (n_en < 8) en_t[n_en] = k;
                n_en++;
            end
            if (bus.timeout_err_o !== 4'b0 && to_k < 0) begin
                to_k = k;
                to_v = bus.timeout_err_o;
            end
            tick();
        end
        n_before = 0;
        for (int i = 0; i < 8; i++) begin
            if (i < n_en && en_t[i] < to_k) n_before++;
        end
        check("to pulses before err", 32'(n_before), 32'd4);
        check("to first pulse",       32'(en_t[0]), 32'd3);
        check("to spacing 1",         32'(en_t[1] - en_t[0]), 32'd11);
        check("to spacing 3",         32'(en_t[3] - en_t[2]), 32'd11);
        check("to err time",          32'(to_k), 32'd46);
        check("to err vector",        32'(to_v), 32'h2);
        check("to rearm pulse",       32'(en_t[4]), 32'd48);
        check("to data",              32'(bus.dfs_data_o), 32'd480);
        bus.dfs_ack_i = 1'b1;
        tick();
        bus.dfs_ack_i = 1'b0;
        tick();
        check("to cur after ack", 32'(bus.cur_idx_o), 32'h05040003);
        check("to busy after ack", 32'(bus.busy_o), 32'd0);

`ifdef DFS_RAMP_LIMIT_EN
        // ch3 5 -> 2 ramps one operating point per transaction
        request(3, 2);
        expect_pulse(3, 320, "ramp step1");
        expect_pulse(3, 360, "ramp step2");
        expect_pulse(3, 400, "ramp step3");
`else
        // ch3 5 -> 2 jumps directly
        request(3, 2);
        expect_pulse(3, 400, "jump");
`endif
        count_en(6, n_quiet);
        check("final quiet", 32'(n_quiet), 32'd0);
        check("final cur", 32'(bus.cur_idx_o), 32'h02040003);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
